// File: rtl/serial_work_loader.sv
// serial_work_loader - 8N1 UART receiver assembling 64-byte work frames into midstate/data2 for the hashing core.
// A frame is published only when all 64 bytes arrive cleanly; errors and idle timeouts discard the partial frame.
module serial_work_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic         osc_clk,
  input  logic         reset_n,
  input  logic         rx_serial,
  output logic [255:0] midstate,
  output logic [255:0] data2,
  output logic         work_valid,
  output logic         frame_err,
  output logic         led
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t       state_q, state_d;
  logic [1:0]   sync_q, fill_q;
  logic         armed_q, armed_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [5:0]   byte_cnt_q, byte_cnt_d;
  logic [511:0] payload_q, payload_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [255:0] midstate_q, data2_q;
  logic         wv_q, fe_q, led_q;

  logic rx_s, tmr_zero, byte_ok, stop_bad, frame_done, tmo_hit;

  assign rx_s     = sync_q[1];
  assign tmr_zero = (tmr_q == '0);

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
      tmr_q      <= '0;
      idx_q      <= 3'd0;
      shreg_q    <= 8'd0;
      byte_cnt_q <= 6'd0;
      payload_q  <= '0;
      tmo_q      <= '0;
      midstate_q <= '0;
      data2_q    <= '0;
      wv_q       <= 1'b0;
      fe_q       <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], rx_serial};
      fill_q     <= {fill_q[0], 1'b1};
      armed_q    <= armed_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      payload_q  <= payload_d;
      tmo_q      <= tmo_d;
      if (frame_done) begin
        midstate_q <= payload_d[255:0];
        data2_q    <= payload_d[511:256];
      end
      wv_q  <= frame_done;
      fe_q  <= stop_bad | tmo_hit;
      led_q <= led_q ^ frame_done;
    end
  end

  // Arming waits for a genuine high on the synchronised line, not the synchroniser's reset value.
  assign armed_d = armed_q | (fill_q[1] & rx_s);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (armed_q && !rx_s) state_d = S_START;
      S_START: if (tmr_zero) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tmr_zero && idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (tmr_zero) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmr_d    = tmr_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    byte_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: if (armed_q && !rx_s) tmr_d = TMR_HALF;
      S_START: begin
        if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else begin
          tmr_d = TMR_FULL;
          idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else begin
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          tmr_d          = TMR_FULL;
        end
      end
      S_STOP: begin
        if (!tmr_zero) tmr_d = tmr_q - 1'b1;
        else begin
          byte_ok  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: tmr_d = '0;
    endcase
  end

  always_comb begin
    payload_d = payload_q;
    if (byte_ok) payload_d[{byte_cnt_q, 3'b000} +: 8] = shreg_q;
    frame_done = byte_ok && (byte_cnt_q == 6'd63);
    // The idle timer only runs between bytes of an unfinished frame.
    tmo_hit = (byte_cnt_q != 6'd0) && (state_q == S_IDLE) && (tmo_q == TMO_LAST);
    byte_cnt_d = byte_cnt_q;
    if (byte_ok) byte_cnt_d = frame_done ? 6'd0 : byte_cnt_q + 6'd1;
    else if (stop_bad || tmo_hit) byte_cnt_d = 6'd0;
    tmo_d = tmo_q;
    if (byte_ok || byte_cnt_d == 6'd0) tmo_d = '0;
    else if (state_q == S_IDLE) tmo_d = tmo_q + 1'b1;
  end

  assign midstate   = midstate_q;
  assign data2      = data2_q;
  assign work_valid = wv_q;
  assign frame_err  = fe_q;
  assign led        = led_q;

endmodule

// File: tb/tb_serial_work_loader.sv
// tb/tb_serial_work_loader.sv - randomized frame stimulus checked against a frame-level reference model.
module tb_serial_work_loader;
  localparam int CPB = 8;
  localparam int TMO = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic [255:0] midstate, data2;
  logic         work_valid, frame_err, led;

  serial_work_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .osc_clk(clk), .reset_n(rst_n), .rx_serial(rx),
    .midstate(midstate), .data2(data2),
    .work_valid(work_valid), .frame_err(frame_err), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wv_cnt = 0, fe_cnt = 0, wv_cyc = 0, fe_cyc = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (work_valid) begin wv_cnt++; wv_cyc = cyc; end
    if (frame_err)  begin fe_cnt++; fe_cyc = cyc; end
    if (work_valid && frame_err) both_cnt++;
  end

  int n_vec = 0, n_miss = 0;
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [511:0] exp_frame = '0;
  logic         exp_led = 1'b0;
  int           exp_wv = 0, exp_fe = 0, last_stop_cyc = 0;
  logic [7:0]   fr[64];

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    last_stop_cyc = cyc;
    bit_out(stop_v);
  endtask

  task automatic send_frame(input int max_gap);
    for (int k = 0; k < 64; k++) begin
      send_byte(fr[k], 1'b1);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) bit_out(1'b1);
    end
    for (int k = 0; k < 64; k++) exp_frame[8*k +: 8] = fr[k];
    exp_wv++;
    exp_led = ~exp_led;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_wv_count"}, 512'(wv_cnt), 512'(exp_wv));
    check({tag, "_fe_count"}, 512'(fe_cnt), 512'(exp_fe));
    check({tag, "_midstate"}, 512'(midstate), 512'(exp_frame[255:0]));
    check({tag, "_data2"}, 512'(data2), 512'(exp_frame[511:256]));
    check({tag, "_led"}, 512'(led), 512'(exp_led));
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 64; k++) fr[k] = 8'($urandom);
  endtask

  initial begin
    #23;
    check("reset_midstate", 512'(midstate), 512'd0);
    check("reset_ctl", 512'({work_valid, frame_err, led}), 512'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) bit_out(1'b1);

    // 1: ascending bytes, back-to-back
    for (int k = 0; k < 64; k++) fr[k] = 8'(k);
    send_frame(0);
    check_outputs("t1");
    check("t1_ms_lo", 512'(midstate[7:0]), 512'h00);
    check("t1_ms_hi", 512'(midstate[255:248]), 512'h1F);
    check("t1_d2_lo", 512'(data2[7:0]), 512'h20);
    check("t1_d2_hi", 512'(data2[255:248]), 512'h3F);
    check("t1_latency", 512'(wv_cyc - last_stop_cyc), 512'd7);

    // 2: two consecutive constant frames
    for (int k = 0; k < 64; k++) fr[k] = 8'hAA;
    send_frame(0);
    check_outputs("t2a");
    for (int k = 0; k < 64; k++) fr[k] = 8'h55;
    send_frame(0);
    check_outputs("t2b");

    // 3: bad stop bit on byte 10, then a clean frame
    rand_frame();
    for (int k = 0; k < 10; k++) send_byte(fr[k], 1'b1);
    send_byte(fr[10], 1'b0);
    exp_fe++;
    repeat (3) bit_out(1'b1);
    check_outputs("t3_err");
    check("t3_err_latency", 512'(fe_cyc - last_stop_cyc), 512'd7);
    rand_frame();
    send_frame(1);
    check_outputs("t3_good");

    // 4: 30 bytes then idle past the timeout
    rand_frame();
    for (int k = 0; k < 30; k++) send_byte(fr[k], 1'b1);
    repeat (250) @(posedge clk);
    #1;
    exp_fe++;
    check_outputs("t4_tmo");
    check("t4_tmo_cycle", 512'(fe_cyc - last_stop_cyc), 512'(TMO + 7));
    rand_frame();
    send_frame(0);
    check_outputs("t4_good");

    // 5: short low glitch on an idle line
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    repeat (4) bit_out(1'b1);
    check_outputs("t5_glitch");
    rand_frame();
    send_frame(0);
    check_outputs("t5_good");

    // 6: reset in the middle of byte 40
    rand_frame();
    for (int k = 0; k < 40; k++) send_byte(fr[k], 1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    exp_frame = '0;
    exp_led   = 1'b0;
    check_outputs("t6_reset");
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) bit_out(1'b1);
    rand_frame();
    send_frame(0);
    check_outputs("t6_good");

    // random frame with random inter-byte gaps
    rand_frame();
    send_frame(2);
    check_outputs("rand");

    check("wv_fe_overlap", 512'(both_cnt), 512'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
